mem_request_arbiter: RTL and testbench

//  Far end of the hazard-unit handshake: produces ihit/dhit and the dREN/dWEN view the

---
 rtl/mem_request_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_request_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_arbiter.sv
// mem_request_arbiter: shares one memory port between instruction fetch and data access
// (data first), producing single-cycle ihit/dhit pulses for the hazard unit.
module mem_request_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  input  logic              halt,
  output logic              ihit,
  output logic              dhit,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_IFETCH = 2'd1;
  localparam logic [1:0] S_DACC   = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam int WAIT_W = $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ERR  = WAIT_W'(MAX_WAIT - 2);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_mem_ren;
  logic              r_mem_wen;
  logic              r_ihit;
  logic              r_dhit;
  logic [DATA_W-1:0] r_iload;
  logic [DATA_W-1:0] r_dload;
  logic              r_halted;
  logic              r_err;
  logic              r_dsup;
  logic [WAIT_W-1:0] r_wait;

  logic w_dpend;
  logic w_dsup_set;
  logic w_dsup_clr;

  // A data access that already hit is not re-issued while the pipeline still shows it
  assign w_dpend    = (dREN | dWEN) & ~r_dsup;
  assign w_dsup_set = (r_state == S_DACC) & mem_ready;
  assign w_dsup_clr = ((r_state == S_IFETCH) & mem_ready) | ~(dREN | dWEN);

  // Transfer sequencing, request latching, hit pulses and timeout tracking
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mem_ren <= 1'b0;
      r_mem_wen <= 1'b0;
      r_ihit    <= 1'b0;
      r_dhit    <= 1'b0;
      r_iload   <= '0;
      r_dload   <= '0;
      r_halted  <= 1'b0;
      r_err     <= 1'b0;
      r_wait    <= '0;
    end else begin
      r_ihit <= 1'b0;
      r_dhit <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (halt && !w_dpend) begin
            r_state  <= S_HALTED;
            r_halted <= 1'b1;
          end else if (w_dpend) begin
            r_state   <= S_DACC;
            r_addr    <= daddr;
            r_wdata   <= dstore;
            r_mem_wen <= dWEN;
            r_mem_ren <= ~dWEN;
            r_wait    <= '0;
          end else if (iREN) begin
            r_state   <= S_IFETCH;
            r_addr    <= iaddr;
            r_mem_ren <= 1'b1;
            r_mem_wen <= 1'b0;
            r_wait    <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_IFETCH, S_DACC: begin
          if (mem_ready) begin
            r_state   <= S_IDLE;
            r_mem_ren <= 1'b0;
            r_mem_wen <= 1'b0;
            if (r_state == S_IFETCH) begin
              r_ihit  <= 1'b1;
              r_iload <= mem_rdata;
            end else begin
              r_dhit <= 1'b1;
              if (!r_mem_wen) begin
                r_dload <= mem_rdata;
              end
            end
          end else begin
            // Keep waiting after a timeout; err only reports it
            if (r_wait != WAIT_LAST) begin
              r_wait <= r_wait + WAIT_W'(1);
            end
            if (r_wait >= WAIT_ERR) begin
              r_err <= 1'b1;
            end
          end
        end
        S_HALTED: begin
          r_state <= S_HALTED;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_ren <= 1'b0;
          r_mem_wen <= 1'b0;
        end
      endcase
    end
  end

  // Data-hit suppression flag; clearing takes precedence
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_dsup <= 1'b0;
    end else if (w_dsup_clr) begin
      r_dsup <= 1'b0;
    end else if (w_dsup_set) begin
      r_dsup <= 1'b1;
    end else begin
      r_dsup <= r_dsup;
    end
  end

  assign ihit      = r_ihit;
  assign dhit      = r_dhit;
  assign iload     = r_iload;
  assign dload     = r_dload;
  assign mem_ren   = r_mem_ren;
  assign mem_wen   = r_mem_wen;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign halted    = r_halted;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Self-checking bench for mem_request_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_mem_request_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 8;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          iREN, dREN, dWEN, halt, mem_ready;
  logic [AW-1:0] iaddr, daddr;
  logic [DW-1:0] dstore, mem_rdata;
  logic          ihit, dhit, mem_ren, mem_wen, halted, err;
  logic [DW-1:0] iload, dload, mem_wdata;
  logic [AW-1:0] mem_addr;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic          m_busy, m_fetch, m_write, m_dsup, m_err, m_halted, m_ihit, m_dhit;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_iload, m_dload;
  int            m_waited;

  mem_request_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .halt(halt), .ihit(ihit), .dhit(dhit),
    .iload(iload), .dload(dload), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .halted(halted), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0; mem_ready = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; mem_rdata = '0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_fetch = 1'b0; m_write = 1'b0; m_dsup = 1'b0; m_err = 1'b0;
    m_halted = 1'b0; m_ihit = 1'b0; m_dhit = 1'b0; m_addr = '0; m_wdata = '0;
    m_iload = '0; m_dload = '0; m_waited = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently applied
  task automatic model_edge();
    logic ih, dh, pend;
    ih = 1'b0; dh = 1'b0;
    pend = (dREN || dWEN) && !m_dsup;
    if (m_halted) begin
      ih = 1'b0;
    end else if (m_busy) begin
      if (mem_ready) begin
        m_busy = 1'b0;
        if (m_fetch) begin
          ih = 1'b1; m_iload = mem_rdata;
        end else begin
          dh = 1'b1;
          if (!m_write) m_dload = mem_rdata;
        end
      end else begin
        if (m_waited < MW - 1) m_waited++;
        if (m_waited == MW - 1) m_err = 1'b1;
      end
    end else if (halt && !pend) begin
      m_halted = 1'b1;
    end else if (pend) begin
      m_busy = 1'b1; m_fetch = 1'b0; m_write = dWEN; m_addr = daddr; m_wdata = dstore;
      m_waited = 0;
    end else if (iREN) begin
      m_busy = 1'b1; m_fetch = 1'b1; m_write = 1'b0; m_addr = iaddr; m_waited = 0;
    end
    if (ih || !(dREN || dWEN)) m_dsup = 1'b0;
    else if (dh) m_dsup = 1'b1;
    m_ihit = ih; m_dhit = dh;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_ren, mem_wen, ihit, dhit, halted, err, iload, dload} !== 70'd0) begin
      errors++;
      $display("FAIL reset_state: got ren=%b wen=%b ihit=%b dhit=%b halted=%b err=%b iload=%h dload=%h, want all 0",
               mem_ren, mem_wen, ihit, dhit, halted, err, iload, dload);
    end
    iREN = 1'b1; iaddr = 32'h10; mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
    tick(); iREN = 1'b0;
    tick(); mem_ready = 1'b0;
    dWEN = 1'b1; daddr = 32'h600; dstore = 32'h1234_5678;
    tick();
    checks++;
    if ({mem_wen, mem_ren, iload} !== {1'b1, 1'b0, 32'hA5A5_0001}) begin
      errors++;
      $display("FAIL reset_pre_write: got wen=%b ren=%b iload=%h, want 1 0 a5a50001", mem_wen, mem_ren, iload);
    end
    #2 nRST = 1'b0;
    #1;
    checks++;
    if ({mem_ren, mem_wen, ihit, dhit, halted, err, iload, dload, mem_addr, mem_wdata} !== 134'd0) begin
      errors++;
      $display("FAIL reset_mid_write: got ren=%b wen=%b iload=%h addr=%h wdata=%h, want all 0",
               mem_ren, mem_wen, iload, mem_addr, mem_wdata);
    end
    dWEN = 1'b0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    iREN = 1'b1; iaddr = 32'h48;
    tick();
    checks++;
    if ({mem_ren, mem_wen, mem_addr} !== {1'b1, 1'b0, 32'h48}) begin
      errors++;
      $display("FAIL reset_to_idle: got ren=%b wen=%b addr=%h, want 1 0 00000048", mem_ren, mem_wen, mem_addr);
    end
  endtask

  task automatic test_fetch();
    do_reset();
    iREN = 1'b1; iaddr = 32'h40; mem_ready = 1'b1; mem_rdata = 32'h8C22_0004;
    tick();
    checks++;
    if ({mem_ren, mem_wen, ihit, mem_addr} !== {1'b1, 1'b0, 1'b0, 32'h40}) begin
      errors++;
      $display("FAIL fetch_strobe: got ren=%b wen=%b ihit=%b addr=%h, want 1 0 0 00000040", mem_ren, mem_wen, ihit, mem_addr);
    end
    iREN = 1'b0;
    tick();
    checks++;
    if ({ihit, dhit, mem_ren, iload} !== {1'b1, 1'b0, 1'b0, 32'h8C22_0004}) begin
      errors++;
      $display("FAIL fetch_hit: got ihit=%b dhit=%b ren=%b iload=%h, want 1 0 0 8c220004", ihit, dhit, mem_ren, iload);
    end
    mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) tick();
    checks++;
    if ({ihit, mem_ren, iload} !== {1'b0, 1'b0, 32'h8C22_0004}) begin
      errors++;
      $display("FAIL fetch_hold: got ihit=%b ren=%b iload=%h, want 0 0 8c220004", ihit, mem_ren, iload);
    end
  endtask

  task automatic test_priority();
    do_reset();
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h100; mem_ready = 1'b0;
    tick();
    checks++;
    if ({mem_ren, mem_wen, mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      errors++;
      $display("FAIL prio_data_first: got ren=%b wen=%b addr=%h, want 1 0 00000100", mem_ren, mem_wen, mem_addr);
    end
    repeat (3) tick();
    mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    checks++;
    if ({dhit, ihit, mem_ren, dload} !== {1'b1, 1'b0, 1'b0, 32'h1111_1111}) begin
      errors++;
      $display("FAIL prio_dhit_cyc5: got dhit=%b ihit=%b ren=%b dload=%h, want 1 0 0 11111111", dhit, ihit, mem_ren, dload);
    end
    mem_rdata = 32'h2222_2222;
    tick();
    checks++;
    if ({mem_ren, dhit, mem_addr} !== {1'b1, 1'b0, 32'h80}) begin
      errors++;
      $display("FAIL prio_no_reissue: got ren=%b dhit=%b addr=%h, want 1 0 00000080", mem_ren, dhit, mem_addr);
    end
    tick();
    checks++;
    if ({ihit, mem_ren, iload} !== {1'b1, 1'b0, 32'h2222_2222}) begin
      errors++;
      $display("FAIL prio_ihit: got ihit=%b ren=%b iload=%h, want 1 0 22222222", ihit, mem_ren, iload);
    end
    iREN = 1'b0;
    tick();
    checks++;
    if ({mem_ren, mem_addr} !== {1'b1, 32'h100}) begin
      errors++;
      $display("FAIL prio_data_after_ihit: got ren=%b addr=%h, want 1 00000100", mem_ren, mem_addr);
    end
    dREN = 1'b0;
    tick();
  endtask

  task automatic test_data_during_fetch();
    do_reset();
    iREN = 1'b1; iaddr = 32'h44; mem_ready = 1'b0;
    tick();
    iREN = 1'b0; dREN = 1'b1; daddr = 32'h300;
    tick();
    checks++;
    if ({mem_ren, mem_wen, mem_addr} !== {1'b1, 1'b0, 32'h44}) begin
      errors++;
      $display("FAIL dfetch_no_abort: got ren=%b wen=%b addr=%h, want 1 0 00000044", mem_ren, mem_wen, mem_addr);
    end
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h3333_3333;
    tick();
    checks++;
    if ({ihit, mem_ren, iload} !== {1'b1, 1'b0, 32'h3333_3333}) begin
      errors++;
      $display("FAIL dfetch_ihit: got ihit=%b ren=%b iload=%h, want 1 0 33333333", ihit, mem_ren, iload);
    end
    mem_rdata = 32'h4444_4444;
    tick();
    checks++;
    if ({mem_ren, ihit, mem_addr} !== {1'b1, 1'b0, 32'h300}) begin
      errors++;
      $display("FAIL dfetch_data_next: got ren=%b ihit=%b addr=%h, want 1 0 00000300", mem_ren, ihit, mem_addr);
    end
    dREN = 1'b0;
    tick();
    checks++;
    if ({dhit, dload} !== {1'b1, 32'h4444_4444}) begin
      errors++;
      $display("FAIL dfetch_dhit: got dhit=%b dload=%h, want 1 44444444", dhit, dload);
    end
  endtask

  task automatic test_write();
    do_reset();
    dREN = 1'b1; daddr = 32'h210; mem_ready = 1'b1; mem_rdata = 32'h5A5A_5A5A;
    tick();
    dREN = 1'b0;
    tick();
    mem_ready = 1'b0;
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
    tick();
    checks++;
    if ({mem_ren, mem_wen, mem_addr, mem_wdata} !== {1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL write_strobe: got ren=%b wen=%b addr=%h wdata=%h, want 0 1 00000200 deadbeef", mem_ren, mem_wen, mem_addr, mem_wdata);
    end
    dREN = 1'b0; dWEN = 1'b0; dstore = 32'h0; daddr = 32'h0;
    tick();
    checks++;
    if ({mem_wen, mem_addr, mem_wdata} !== {1'b1, 32'h200, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL write_latched: got wen=%b addr=%h wdata=%h, want 1 00000200 deadbeef", mem_wen, mem_addr, mem_wdata);
    end
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_0000;
    tick();
    checks++;
    if ({dhit, mem_wen, dload} !== {1'b1, 1'b0, 32'h5A5A_5A5A}) begin
      errors++;
      $display("FAIL write_dload_kept: got dhit=%b wen=%b dload=%h, want 1 0 5a5a5a5a", dhit, mem_wen, dload);
    end
  endtask

  task automatic test_random();
    int rem;
    logic exp_ren, exp_wen;
    do_reset();
    model_reset();
    rem = -1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) iREN = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 2) == 0) dREN = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 2) == 0) dWEN = ($urandom_range(0, 9) < 2);
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; mem_rdata = $urandom;
      if (mem_ren || mem_wen) begin
        if (rem < 0) rem = $urandom_range(0, 3);
        mem_ready = (rem == 0);
        rem--;
      end else begin
        rem = -1;
        mem_ready = ($urandom_range(0, 1) == 1);
      end
      model_edge();
      tick();
      exp_ren = m_busy && !m_write;
      exp_wen = m_busy && m_write;
      checks++;
      if ({mem_ren, mem_wen, ihit, dhit, err, halted, iload, dload} !==
          {exp_ren, exp_wen, m_ihit, m_dhit, m_err, m_halted, m_iload, m_dload} ||
          (m_busy && mem_addr !== m_addr) || (exp_wen && mem_wdata !== m_wdata)) begin
        errors++;
        $display("FAIL random_c%0d: got ren=%b wen=%b ihit=%b dhit=%b addr=%h wdata=%h iload=%h dload=%h, want %b %b %b %b %h %h %h %h",
                 c, mem_ren, mem_wen, ihit, dhit, mem_addr, mem_wdata, iload, dload,
                 exp_ren, exp_wen, m_ihit, m_dhit, m_addr, m_wdata, m_iload, m_dload);
      end
    end
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
  endtask

  task automatic test_timeout_halt();
    do_reset();
    dREN = 1'b1; daddr = 32'h500; mem_ready = 1'b0;
    tick();
    dREN = 1'b0;
    for (int k = 1; k <= MW; k++) begin
      tick();
      checks++;
      if ({err, mem_ren} !== {(k >= MW - 1), 1'b1}) begin
        errors++;
        $display("FAIL timeout_wait%0d: got err=%b ren=%b, want %b 1", k, err, mem_ren, (k >= MW - 1));
      end
    end
    mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    checks++;
    if ({dhit, err, dload} !== {1'b1, 1'b1, 32'h7777_7777}) begin
      errors++;
      $display("FAIL timeout_late_ready: got dhit=%b err=%b dload=%h, want 1 1 77777777", dhit, err, dload);
    end
    halt = 1'b1;
    tick();
    iREN = 1'b1; dREN = 1'b1; daddr = 32'h504;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({halted, mem_ren, mem_wen, ihit, dhit, err} !== 6'b100001) begin
        errors++;
        $display("FAIL halted_%0d: got halted=%b ren=%b wen=%b ihit=%b dhit=%b err=%b, want 1 0 0 0 0 1",
                 k, halted, mem_ren, mem_wen, ihit, dhit, err);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_data_during_fetch();
    test_write();
    test_random();
    test_timeout_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
